ws2812_rx: RTL and testbench

- One-wire WS2812 stream decoder/repeater: the pixel-side counterpart of the team's WS2812 transmitter.
- Samples a WS2812 bit stream, classifies each bit by its high-pulse width and assembles the first 24 bits (MSB first) of a frame into a parallel word.
- Forwards all later bits of the frame unchanged on dout, like a real WS2812 in a chain.
- Used for loopback verification of the transmitter on the icestick and as a daisy-chain tap.

---
 rtl/ws2812_rx.sv | 186 ++++++++++++++++++
 tb/tb_ws2812_rx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// WS2812 one-wire stream decoder / repeater.
// Classifies each bit by the width of its high pulse and assembles the first
// 24 bits of a frame (MSB first) into a parallel word. All later bits of the
// same frame are forwarded on dout, as a pixel in a daisy chain would do.
module ws2812_rx #(
    parameter int unsigned F_CLK  = 48_000_000, // clock frequency in Hz; counts below assume 48 MHz
    parameter int unsigned N_THR  = 25,         // high >= N_THR cycles decodes as 1
    parameter int unsigned N_HMIN = 4,          // shortest legal high pulse
    parameter int unsigned N_HMAX = 60,         // longest legal high pulse
    parameter int unsigned N_RES  = 2400        // low time that marks the latch gap
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] data,
    output logic        valid,
    output logic        frame_err,
    output logic        dout,
    output logic        bsy
);

    localparam int unsigned CW = $clog2(N_RES + 1);

    // cnt_reg is cleared in the cycle an edge of din_s is seen, so when an
    // edge arrives it holds (level width - 1). While the level persists, the
    // level has lasted cnt_reg + 2 cycles including the current one.
    localparam logic [CW-1:0] THR_M1  = CW'(N_THR - 1);
    localparam logic [CW-1:0] HMIN_M1 = CW'(N_HMIN - 1);
    localparam logic [CW-1:0] HMAX_M1 = CW'(N_HMAX - 1);
    localparam logic [CW-1:0] RES_M2  = CW'(N_RES - 2);
    localparam logic [CW-1:0] CNT_SAT = {CW{1'b1}};

    // Reject parameter sets whose timing windows do not nest.
    generate
        if (F_CLK == 0 || N_HMIN < 1 || N_HMIN > N_THR || N_THR > N_HMAX || N_RES < 2) begin : g_bad_params
            $error("ws2812_rx: inconsistent timing parameters");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_t;

    state_t        state_reg;
    logic [1:0]    sync_reg;
    logic          prev_reg;
    logic [CW-1:0] cnt_reg;
    logic [4:0]    bit_cnt_reg;
    logic [22:0]   shift_reg;
    logic          pass_reg;
    logic [23:0]   data_reg;
    logic          valid_reg;
    logic          frame_err_reg;
    logic          dout_reg;

    logic          din_s;
    logic          rise_w;
    logic          fall_w;
    logic          edge_w;
    logic          bit_val;
    logic [23:0]   shift_next;

    assign din_s      = sync_reg[1];
    assign rise_w     = din_s & ~prev_reg;
    assign fall_w     = ~din_s & prev_reg;
    assign edge_w     = din_s ^ prev_reg;
    assign bit_val    = (cnt_reg >= THR_M1);
    assign shift_next = {shift_reg, bit_val};

    // Two-flop synchronizer for the asynchronous line plus edge-detect history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= 2'b00;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], din};
            prev_reg <= din_s;
        end
    end

    // Level-width counter: cleared on every edge, saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (edge_w) begin
            cnt_reg <= '0;
        end else if (cnt_reg != CNT_SAT) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Frame state machine: bit classification, capture, gap and error handling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_SYNC;
            bit_cnt_reg   <= 5'd0;
            shift_reg     <= '0;
            pass_reg      <= 1'b0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                ST_SYNC: begin
                    // Nothing is trusted until a full low gap has been seen.
                    bit_cnt_reg <= 5'd0;
                    pass_reg    <= 1'b0;
                    if (!din_s && !edge_w && (cnt_reg >= RES_M2)) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (rise_w) begin
                        state_reg <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (fall_w) begin
                        if (cnt_reg < HMIN_M1) begin
                            frame_err_reg <= 1'b1;
                            bit_cnt_reg   <= 5'd0;
                            pass_reg      <= 1'b0;
                            state_reg     <= ST_SYNC;
                        end else begin
                            if (!pass_reg) begin
                                shift_reg   <= shift_next[22:0];
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                                // The 24th bit completes the word; forwarding starts
                                // now, while the line is low.
                                if (bit_cnt_reg == 5'd23) begin
                                    data_reg  <= shift_next;
                                    valid_reg <= 1'b1;
                                    pass_reg  <= 1'b1;
                                end
                            end
                            state_reg <= ST_LOW;
                        end
                    end else if (cnt_reg >= HMAX_M1) begin
                        // Still high after N_HMAX cycles: pulse is too long.
                        frame_err_reg <= 1'b1;
                        bit_cnt_reg   <= 5'd0;
                        pass_reg      <= 1'b0;
                        state_reg     <= ST_SYNC;
                    end
                end
                ST_LOW: begin
                    if (rise_w) begin
                        state_reg <= ST_HIGH;
                    end else if (cnt_reg >= RES_M2) begin
                        // Latch gap: a partially received word is an error.
                        if ((bit_cnt_reg != 5'd0) && (bit_cnt_reg < 5'd24)) begin
                            frame_err_reg <= 1'b1;
                        end
                        bit_cnt_reg <= 5'd0;
                        pass_reg    <= 1'b0;
                        state_reg   <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_SYNC;
                end
            endcase
        end
    end

    // Repeater output: synchronized line gated by the pass flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_reg <= 1'b0;
        end else begin
            dout_reg <= din_s & pass_reg;
        end
    end

    assign data      = data_reg;
    assign valid     = valid_reg;
    assign frame_err = frame_err_reg;
    assign dout      = dout_reg;
    assign bsy       = (state_reg == ST_HIGH) || (state_reg == ST_LOW);

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed testbench for ws2812_rx: drives WS2812 waveforms on din and checks
// the captured word, pulse counts, error pulses and the forwarded stream.
`timescale 1ns/1ps
module tb_ws2812_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din = 1'b0;
    logic [23:0] data;
    logic        valid;
    logic        frame_err;
    logic        dout;
    logic        bsy;

    int errors = 0;
    int checks = 0;

    // Event counters maintained by the monitor, cleared by each scenario.
    int valid_cnt    = 0;
    int err_cnt      = 0;
    int both_cnt     = 0;
    int dout_hi_cnt  = 0;
    int dout_bad_cnt = 0;

    // fwd marks the stretch of din the bench expects to see repeated on dout.
    logic fwd    = 1'b0;
    logic din_h1 = 1'b0;
    logic din_h2 = 1'b0;
    logic fwd_h1 = 1'b0;
    logic fwd_h2 = 1'b0;

    ws2812_rx dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .dout      (dout),
        .bsy       (bsy)
    );

    always #10 clk = ~clk;

    // Sample just after each rising edge. din captured at edge k reaches dout
    // after edge k+2 (two synchronizer flops and the output flop).
    always @(posedge clk) begin
        #1;
        if (valid === 1'b1) valid_cnt++;
        if (frame_err === 1'b1) err_cnt++;
        if ((valid === 1'b1) && (frame_err === 1'b1)) both_cnt++;
        if (dout === 1'b1) dout_hi_cnt++;
        if (dout !== (din_h2 & fwd_h2)) dout_bad_cnt++;
        din_h2 = din_h1;
        fwd_h2 = fwd_h1;
        din_h1 = din;
        fwd_h1 = fwd;
    end

    // Global time limit.
    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 80000 cycles, required completion");
        $fatal(1, "timeout");
    end

    task automatic clear_counts();
        valid_cnt    = 0;
        err_cnt      = 0;
        both_cnt     = 0;
        dout_hi_cnt  = 0;
        dout_bad_cnt = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pulse(input int hi, input int lo);
        din = 1'b1;
        wait_cycles(hi);
        din = 1'b0;
        wait_cycles(lo);
    endtask

    task automatic send_bit(input logic b);
        if (b) send_pulse(35, 30);
        else   send_pulse(18, 40);
    endtask

    task automatic send_range(input logic [23:0] w, input int msb, input int lsb);
        for (int i = msb; i >= lsb; i--) send_bit(w[i]);
    endtask

    task automatic send_gap();
        din = 1'b0;
        wait_cycles(2400);
    endtask

    task automatic test_reset();
        wait_cycles(3);
        checks++; if (data !== 24'h0) begin errors++; $display("FAIL reset_data: got %h expected %h", data, 24'h0); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b expected 0", dout); end
        checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL reset_bsy: got %b expected 0", bsy); end
        rst = 1'b1;
        $display("test_reset: outputs after reset data=%h bsy=%b", data, bsy);
    endtask

    task automatic test_basic();
        clear_counts();
        send_gap();
        send_range(24'hA5C3F0, 23, 0);
        send_gap();
        checks++; if (data !== 24'hA5C3F0) begin errors++; $display("FAIL basic_data: got %h expected %h", data, 24'hA5C3F0); end
        checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL basic_valid_count: got %0d expected 1", valid_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL basic_frame_err_count: got %0d expected 0", err_cnt); end
        checks++; if (dout_hi_cnt !== 0) begin errors++; $display("FAIL basic_dout_high: got %0d high cycles expected 0", dout_hi_cnt); end
        checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL basic_bsy_after_gap: got %b expected 0", bsy); end
        $display("test_basic: frame A5C3F0 -> data=%h valid_pulses=%0d", data, valid_cnt);
    endtask

    task automatic test_forward();
        clear_counts();
        send_range(24'h123456, 23, 0);
        checks++; if (data !== 24'h123456) begin errors++; $display("FAIL fwd_data_first: got %h expected %h", data, 24'h123456); end
        fwd = 1'b1;
        send_range(24'hABCDEF, 23, 0);
        checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL fwd_bsy_in_frame: got %b expected 1", bsy); end
        fwd = 1'b0;
        send_gap();
        checks++; if (data !== 24'h123456) begin errors++; $display("FAIL fwd_data_hold: got %h expected %h", data, 24'h123456); end
        checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL fwd_valid_count: got %0d expected 1", valid_cnt); end
        // ABCDEF has 17 ones (35 high) and 7 zeros (18 high).
        checks++; if (dout_hi_cnt !== 721) begin errors++; $display("FAIL fwd_dout_high: got %0d high cycles expected 721", dout_hi_cnt); end
        checks++; if (dout_bad_cnt !== 0) begin errors++; $display("FAIL fwd_dout_waveform: got %0d differing cycles expected 0", dout_bad_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL fwd_frame_err_count: got %0d expected 0", err_cnt); end
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL fwd_dout_after_gap: got %b expected 0", dout); end
        $display("test_forward: data=%h dout_high_cycles=%0d", data, dout_hi_cnt);
    endtask

    task automatic test_back_to_back();
        clear_counts();
        // Last bit of the first frame is a 1 whose low is exactly the gap.
        send_range(24'h13579B, 23, 1);
        send_pulse(35, 2400);
        checks++; if (data !== 24'h13579B) begin errors++; $display("FAIL b2b_data_first: got %h expected %h", data, 24'h13579B); end
        send_range(24'h2468AC, 23, 0);
        send_gap();
        checks++; if (data !== 24'h2468AC) begin errors++; $display("FAIL b2b_data_second: got %h expected %h", data, 24'h2468AC); end
        checks++; if (valid_cnt !== 2) begin errors++; $display("FAIL b2b_valid_count: got %0d expected 2", valid_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL b2b_frame_err_count: got %0d expected 0", err_cnt); end
        checks++; if (dout_hi_cnt !== 0) begin errors++; $display("FAIL b2b_dout_high: got %0d high cycles expected 0", dout_hi_cnt); end
        $display("test_back_to_back: data=%h valid_pulses=%0d", data, valid_cnt);
    endtask

    task automatic test_threshold();
        clear_counts();
        send_pulse(24, 40);
        send_range(24'h3C3C3C, 22, 0);
        send_gap();
        checks++; if (data !== 24'h3C3C3C) begin errors++; $display("FAIL thr_high24: got %h expected %h", data, 24'h3C3C3C); end
        send_pulse(25, 40);
        send_range(24'h3C3C3C, 22, 0);
        send_gap();
        checks++; if (data !== 24'hBC3C3C) begin errors++; $display("FAIL thr_high25: got %h expected %h", data, 24'hBC3C3C); end
        checks++; if (valid_cnt !== 2) begin errors++; $display("FAIL thr_valid_count: got %0d expected 2", valid_cnt); end
        clear_counts();
        send_pulse(3, 40);
        send_range(24'h3C3C3C, 22, 0);
        send_gap();
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL thr_short_err: got %0d pulses expected 1", err_cnt); end
        checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL thr_short_valid: got %0d pulses expected 0", valid_cnt); end
        checks++; if (data !== 24'hBC3C3C) begin errors++; $display("FAIL thr_short_data_hold: got %h expected %h", data, 24'hBC3C3C); end
        clear_counts();
        send_pulse(60, 40);
        send_range(24'h3C3C3C, 22, 0);
        send_gap();
        checks++; if (data !== 24'hBC3C3C) begin errors++; $display("FAIL thr_high60_data: got %h expected %h", data, 24'hBC3C3C); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL thr_high60_err: got %0d pulses expected 0", err_cnt); end
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL thr_valid_and_err: got %0d overlapping cycles expected 0", both_cnt); end
        $display("test_threshold: last data=%h", data);
    endtask

    task automatic test_short_frame();
        clear_counts();
        send_range(24'hFFFFFF, 23, 14);
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL short_err_before_gap: got %0d pulses expected 0", err_cnt); end
        send_gap();
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL short_err_at_gap: got %0d pulses expected 1", err_cnt); end
        checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL short_valid: got %0d pulses expected 0", valid_cnt); end
        checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL short_bsy: got %b expected 0", bsy); end
        clear_counts();
        send_range(24'h00FF00, 23, 0);
        send_gap();
        checks++; if (data !== 24'h00FF00) begin errors++; $display("FAIL short_next_data: got %h expected %h", data, 24'h00FF00); end
        checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL short_next_valid: got %0d pulses expected 1", valid_cnt); end
        $display("test_short_frame: recovered data=%h", data);
    endtask

    task automatic test_stuck_high();
        clear_counts();
        send_range(24'h5A5A5A, 23, 16);
        din = 1'b1;
        wait_cycles(55);
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL stuck_err_early: got %0d pulses expected 0", err_cnt); end
        wait_cycles(15);
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL stuck_err: got %0d pulses expected 1", err_cnt); end
        checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL stuck_bsy: got %b expected 0", bsy); end
        wait_cycles(30);
        din = 1'b0;
        wait_cycles(40);
        send_range(24'hFFFFFF, 23, 19);
        send_gap();
        send_range(24'h0F0F0F, 23, 0);
        send_gap();
        checks++; if (data !== 24'h0F0F0F) begin errors++; $display("FAIL stuck_next_data: got %h expected %h", data, 24'h0F0F0F); end
        checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL stuck_valid: got %0d pulses expected 1", valid_cnt); end
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL stuck_err_total: got %0d pulses expected 1", err_cnt); end
        $display("test_stuck_high: recovered data=%h", data);
    endtask

    task automatic test_midframe_reset();
        clear_counts();
        send_range(24'hC0FFEE, 23, 12);
        rst = 1'b0;
        #1;
        checks++; if (data !== 24'h0) begin errors++; $display("FAIL mrst_data: got %h expected %h", data, 24'h0); end
        checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL mrst_bsy: got %b expected 0", bsy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b expected 0", valid); end
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL mrst_dout: got %b expected 0", dout); end
        wait_cycles(2);
        rst = 1'b1;
        send_range(24'hC0FFEE, 11, 0);
        send_gap();
        checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL mrst_tail_valid: got %0d pulses expected 0", valid_cnt); end
        send_range(24'hFFFFFF, 23, 0);
        send_gap();
        checks++; if (data !== 24'hFFFFFF) begin errors++; $display("FAIL mrst_next_data: got %h expected %h", data, 24'hFFFFFF); end
        checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL mrst_valid_count: got %0d expected 1", valid_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL mrst_frame_err: got %0d pulses expected 0", err_cnt); end
        $display("test_midframe_reset: recovered data=%h", data);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forward();
        test_back_to_back();
        test_threshold();
        test_short_frame();
        test_stuck_high();
        test_midframe_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
